// File: rtl/bsg_mem_ctrl_pkg.sv
// Shared definitions for the bsg memory-port controllers.
// The request struct is a macro so each controller can size it from its own parameters.
`ifndef BSG_MEM_CTRL_REQ_S
`define BSG_MEM_CTRL_REQ_S
`define BSG_MEM_CTRL_REQ_T(addr_w, data_w, mask_w) \
    struct packed {                                \
        logic                  w;                  \
        logic [(addr_w)-1:0]   addr;               \
        logic [(data_w)-1:0]   data;               \
        logic [(mask_w)-1:0]   mask;               \
    }
`endif

package bsg_mem_ctrl_pkg;

    localparam int bsg_byte_width_gp = 8;

endpackage

// File: rtl/bsg_mem_1rw_byte_mask_ctrl_chk.sv
// Protocol checks for the byte-mask memory controller; simulation only.
module bsg_mem_1rw_byte_mask_ctrl_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic yumi_i,
    input logic v_o,
    input logic push_i,
    input logic full_i
);

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
    a_no_push_on_full:  assert property (@(posedge clk_i) disable iff (!reset_n_i) push_i |-> !full_i);

endmodule

// File: rtl/bsg_mem_1rw_byte_mask_ctrl_rbuf.sv
// Register FIFO that holds read responses until the client takes them.
// Occupancy is exported so the parent can compute request credits.
module bsg_mem_1rw_byte_mask_ctrl_rbuf #(
    parameter  int els_p   = 3,
    parameter  int width_p = 32,
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                push_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                pop_i,
    output logic                v_o,
    output logic [width_p-1:0]  data_o,
    output logic                full_o,
    output logic [cnt_w_lp-1:0] count_o
);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_wptr;
    logic [ptr_w_lp-1:0] r_rptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    function automatic logic [ptr_w_lp-1:0] f_next_ptr(input logic [ptr_w_lp-1:0] p);
        if (p == ptr_w_lp'(els_p - 1)) begin
            return '0;
        end else begin
            return p + ptr_w_lp'(1);
        end
    endfunction

    assign w_empty = (r_count == cnt_w_lp'(0));
    assign full_o  = (r_count == cnt_w_lp'(els_p));
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~w_empty;
    assign v_o     = ~w_empty;
    assign count_o = r_count;

    // An empty buffer presents zero rather than a stale entry.
    always_comb begin
        data_o = '0;
        if (!w_empty) begin
            data_o = r_mem[r_rptr];
        end else begin
            data_o = '0;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= f_next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_w_lp'(1);
                2'b01:   r_count <= r_count - cnt_w_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_byte_mask_ctrl.sv
// Initiator-side controller for a 1RW byte-masked synchronous SRAM with a
// credit-protected read response buffer.
module bsg_mem_1rw_byte_mask_ctrl
    import bsg_mem_ctrl_pkg::*;
#(
    parameter  int els_p         = 16,
    parameter  int data_width_p  = 32,
    parameter  int resp_els_p    = 3,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int mask_width_lp = data_width_p / bsg_byte_width_gp
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     v_i,
    output logic                     ready_and_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,

    output logic                     v_o,
    output logic [data_width_p-1:0]  data_o,
    input  logic                     yumi_i,

    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [data_width_p-1:0]  mem_data_o,
    output logic [mask_width_lp-1:0] mem_write_mask_o,
    input  logic [data_width_p-1:0]  mem_data_i
);

    localparam int cnt_w_lp = $clog2(resp_els_p + 1);
    localparam int tot_w_lp = $clog2(resp_els_p + 2);

    typedef `BSG_MEM_CTRL_REQ_T(addr_width_lp, data_width_p, mask_width_lp) req_s;

    req_s                w_req;
    logic                r_rd_pending;
    logic                w_accept;
    logic                w_rd_accept;
    logic                w_full;
    logic [cnt_w_lp-1:0] w_occ;
    logic [tot_w_lp-1:0] w_total;

    assign w_req = '{w: w_i, addr: addr_i, data: data_i, mask: write_mask_i};

    // Credits cover buffered responses plus the one read still at the memory,
    // so ready depends on registered state only.
    assign w_total     = tot_w_lp'(w_occ) + tot_w_lp'(r_rd_pending);
    assign ready_and_o = (w_total < tot_w_lp'(resp_els_p));
    assign w_accept    = v_i & ready_and_o;
    assign w_rd_accept = w_accept & ~w_req.w;

    // Memory port: pass-through, with all-zero-mask writes suppressed.
    always_comb begin
        mem_v_o          = 1'b0;
        mem_w_o          = w_req.w;
        mem_addr_o       = w_req.addr;
        mem_data_o       = w_req.data;
        mem_write_mask_o = w_req.mask;
        if (w_accept) begin
            mem_v_o = ~w_req.w | (|w_req.mask);
        end else begin
            mem_v_o = 1'b0;
        end
    end

    // Read in flight: its data appears on mem_data_i during the next cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_pending <= 1'b0;
        end else begin
            r_rd_pending <= w_rd_accept;
        end
    end

    bsg_mem_1rw_byte_mask_ctrl_rbuf #(
        .els_p   (resp_els_p),
        .width_p (data_width_p)
    ) u_rbuf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (r_rd_pending),
        .data_i    (mem_data_i),
        .pop_i     (yumi_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .full_o    (w_full),
        .count_o   (w_occ)
    );

    bsg_mem_1rw_byte_mask_ctrl_chk u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .yumi_i    (yumi_i),
        .v_o       (v_o),
        .push_i    (r_rd_pending),
        .full_i    (w_full)
    );

endmodule

// File: tb/tb_bsg_mem_1rw_byte_mask_ctrl.sv
// Directed plus randomized bench for bsg_mem_1rw_byte_mask_ctrl, with a behavioural
// SRAM and a response-queue reference model.
module tb_bsg_mem_1rw_byte_mask_ctrl;

    localparam int ELS = 16;
    localparam int DW  = 32;
    localparam int RE  = 3;
    localparam int AW  = 4;
    localparam int MW  = 4;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          v_i;
    logic          w_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic [MW-1:0] write_mask_i;
    logic          yumi_i;
    logic [DW-1:0] mem_data_i;
    wire           ready_and_o;
    wire           v_o;
    wire  [DW-1:0] data_o;
    wire           mem_v_o;
    wire           mem_w_o;
    wire  [AW-1:0] mem_addr_o;
    wire  [DW-1:0] mem_data_o;
    wire  [MW-1:0] mem_write_mask_o;

    always #5 clk = ~clk;

    bsg_mem_1rw_byte_mask_ctrl #(.els_p(ELS), .data_width_p(DW), .resp_els_p(RE)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .v_i(v_i), .ready_and_o(ready_and_o), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .write_mask_i(write_mask_i),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_write_mask_o(mem_write_mask_o),
        .mem_data_i(mem_data_i)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 5) return 32'hFFFF_FFFF;
        return 32'h3C00_0000 | (a * 32'h0001_0101);
    endfunction

    // Behavioural synchronous 1RW SRAM driven by the DUT's memory port.
    logic [DW-1:0] sram [ELS];
    logic          mem_fill;
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < ELS; i++) sram[i] <= init_val(i);
        end else if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < MW; b++)
                    if (mem_write_mask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
            end else begin
                mem_data_i <= sram[mem_addr_o];
            end
        end
    end

    // Reference model: shadow memory plus queue of expected responses with due cycle.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } resp_t;
    resp_t         rq[$];
    logic [DW-1:0] shadow [ELS];
    int            cyc;
    int            n_vec;
    int            n_err;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m, input logic y,
                        output logic acc, output logic o_rdy, output logic o_vo,
                        output logic [DW-1:0] o_do);
        logic          e_rdy;
        logic          e_vo;
        logic [DW-1:0] e_do;
        e_rdy = (rq.size() < RE);
        e_vo  = (rq.size() > 0) && (rq[0].due <= cyc);
        e_do  = e_vo ? rq[0].data : 32'h0;
        v_i = v; w_i = w; addr_i = a; data_i = d; write_mask_i = m;
        yumi_i = y & e_vo;
        acc = v & e_rdy;
        @(negedge clk);
        o_rdy = ready_and_o; o_vo = v_o; o_do = data_o;
        check("ready", {31'h0, ready_and_o}, {31'h0, e_rdy});
        check("v_o", {31'h0, v_o}, {31'h0, e_vo});
        check("data_o", data_o, e_do);
        check("mem_v", {31'h0, mem_v_o}, {31'h0, acc & (~w | (|m))});
        if (v) begin
            check("mem_pass", {mem_w_o, mem_addr_o, mem_write_mask_o, 23'h0},
                  {w, a, m, 23'h0});
            check("mem_wdata", mem_data_o, d);
        end
        @(posedge clk);
        if (reset_n_i) begin
            if (yumi_i) void'(rq.pop_front());
            if (acc) begin
                if (w) begin
                    for (int b = 0; b < MW; b++)
                        if (m[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
                end else begin
                    rq.push_back('{data: shadow[a], due: cyc + 2});
                end
            end
        end
        cyc++;
        #1;
    endtask

    logic          acc, rdy, vo;
    logic [DW-1:0] dout;
    logic [3:0]    accs;
    int            first_v, last_v, nv, nacc;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        for (int i = 0; i < ELS; i++) shadow[i] = init_val(i);
        mem_fill = 1'b1; reset_n_i = 1'b0;
        v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; write_mask_i = '0; yumi_i = 1'b0;
        mem_data_i = '0;

        // Reset held: ready high, no response, no memory access.
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        check("rst_ready", {31'h0, rdy}, 32'h1);
        check("rst_v_o", {31'h0, vo}, 32'h0);
        mem_fill = 1'b0;
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        reset_n_i = 1'b1;

        // Byte-masked write over all-ones, then read back with latency 2.
        step(1, 1, 5, 32'hA1B2_C3D4, 4'b0101, 0, acc, rdy, vo, dout);
        step(1, 0, 5, 0, 0, 0, acc, rdy, vo, dout);
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        check("rd5_t1_v", {31'h0, vo}, 32'h0);
        step(0, 0, 0, 0, 0, 1, acc, rdy, vo, dout);
        check("rd5_t2_v", {31'h0, vo}, 32'h1);
        check("rd5_data", dout, 32'hFFB2_FFD4);

        // Zero-mask write is consumed without touching memory.
        step(1, 1, 7, 32'hDEAD_BEEF, 4'b0000, 0, acc, rdy, vo, dout);
        check("zm_acc", {31'h0, acc}, 32'h1);
        step(1, 0, 7, 0, 0, 0, acc, rdy, vo, dout);
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        step(0, 0, 0, 0, 0, 1, acc, rdy, vo, dout);
        check("zm_data", dout, init_val(7));

        // Backpressure: four reads with no yumi, only three accepted.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, AW'(i + 1), 0, 0, 0, acc, rdy, vo, dout);
            accs[i] = rdy;
        end
        check("bp_ready_seq", {28'h0, accs}, 32'h7);
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        check("bp_stalled", {31'h0, rdy}, 32'h0);
        step(0, 0, 0, 0, 0, 1, acc, rdy, vo, dout);
        check("bp_head", dout, init_val(1));
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        check("bp_ready_after_yumi", {31'h0, rdy}, 32'h1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, acc, rdy, vo, dout);

        // Simultaneous push and pop with two entries buffered.
        for (int i = 0; i < 3; i++) step(1, 0, AW'(8 + i), 0, 0, 0, acc, rdy, vo, dout);
        step(0, 0, 0, 0, 0, 1, acc, rdy, vo, dout);
        check("sim_pop_head", dout, init_val(8));
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        check("sim_ready", {31'h0, rdy}, 32'h1);
        check("sim_order", dout, init_val(9));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, acc, rdy, vo, dout);

        // Throughput: 16 reads back to back with yumi held high.
        first_v = -1; last_v = -1; nv = 0; nacc = 0;
        for (int i = 0; i < 19; i++) begin
            step(i < 16, 0, AW'(i), 0, 0, 1, acc, rdy, vo, dout);
            if (acc) nacc++;
            if (vo) begin
                nv++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        check("tp_accepts", nacc, 32'd16);
        check("tp_responses", nv, 32'd16);
        check("tp_first", first_v, 32'd2);
        check("tp_span", last_v - first_v, 32'd15);

        // Reset mid-stream with two responses buffered.
        step(1, 0, 11, 0, 0, 0, acc, rdy, vo, dout);
        step(1, 0, 12, 0, 0, 0, acc, rdy, vo, dout);
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        check("pre_rst_v", {31'h0, vo}, 32'h1);
        reset_n_i = 1'b0;
        #1;
        check("async_rst_v_o", {31'h0, v_o}, 32'h0);
        check("async_rst_ready", {31'h0, ready_and_o}, 32'h1);
        check("async_rst_data", data_o, 32'h0);
        rq.delete();
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        reset_n_i = 1'b1;
        step(1, 0, 5, 0, 0, 0, acc, rdy, vo, dout);
        step(0, 0, 0, 0, 0, 0, acc, rdy, vo, dout);
        step(0, 0, 0, 0, 0, 1, acc, rdy, vo, dout);
        check("mem_kept", dout, 32'hFFB2_FFD4);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3), AW'($urandom),
                 $urandom, ($urandom_range(0, 7) == 0) ? 4'b0000 : MW'($urandom),
                 1'($urandom_range(0, 9) < 7), acc, rdy, vo, dout);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, acc, rdy, vo, dout);
        check("drained", rq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_mem_1rw_byte_mask_ctrl.md
# bsg_mem_1rw_byte_mask_ctrl

Initiator-side controller for a single-port synchronous byte-masked memory (1 read or 1 write per cycle, read data valid the cycle after the access). It accepts valid/ready requests from a core-side client and drives the memory port. It captures read data into a credit-protected response buffer, so the client may stall responses without losing data. It sits between a cache or DMA engine and a byte-writable SRAM macro.

## Interface
- els_p, none (required): memory depth in words.
- data_width_p, none (required): word width; multiple of 8.
- resp_els_p, 3: response buffer depth; at least 3 is required for one read per cycle.
- addr_width_lp, clog2(els_p) (safe): address width.
- mask_width_lp, data_width_p/8: byte mask width.
- clk_i  in  1  sole clock.
- reset_n_i  in  1  reset, asynchronous and active-low; one clock; reset is asynchronous and active-low.
- v_i  in  1  request valid.
- ready_and_o  out  1  request ready; a request is accepted when v_i & ready_and_o.
- w_i  in  1  1 = write, 0 = read.
- addr_i  in  addr_width_lp  word address.
- data_i  in  data_width_p  write data.
- write_mask_i  in  mask_width_lp  bit k enables byte k on writes; ignored on reads.
- v_o  out  1  read response valid.
- data_o  out  data_width_p  read response data.
- yumi_i  in  1  consumer takes the response; legal only when v_o=1.
- mem_v_o  out  1  memory access enable.
- mem_w_o  out  1  memory write enable.
- mem_addr_o  out  addr_width_lp  memory address.
- mem_data_o  out  data_width_p  memory write data.
- mem_write_mask_o  out  mask_width_lp  memory byte mask.
- mem_data_i  in  data_width_p  memory read data, valid the cycle after a read.

## Operation
- Memory-side outputs are combinational from the accepted request: mem_v_o = v_i & ready_and_o & (~w_i | (|write_mask_i)). mem_w_o, mem_addr_o, mem_data_o and mem_write_mask_o pass w_i, addr_i, data_i and write_mask_i straight through.
- A write with an all-zero mask is accepted and consumed, but issues no memory access (mem_v_o = 0).
- Writes produce no response.
- Read tracking:
  - An accepted read sets the in-flight flag `rd_pending`.
  - On the next cycle, mem_data_i is pushed into the response buffer and `rd_pending` clears, unless another read is accepted in that same cycle.
- Credit count `total` = buffer occupancy + rd_pending, range 0..resp_els_p.
- ready_and_o = (total < resp_els_p). It is a function of registered state only: no path from v_i, w_i or yumi_i.
- When the buffer is full, writes also stall. This is intentional, to keep ready state-only.
- Response buffer: FIFO. v_o = not empty, data_o = head entry. yumi_i pops the head.
- A push and a pop in the same cycle leave occupancy unchanged. Push on a full buffer is impossible by construction, and is asserted in simulation.
- yumi_i while v_o = 0 is illegal; a simulation assertion fires.

## Timing
- Reset values:
  - ready_and_o = 1, v_o = 0, mem_v_o = 0.
  - data_o = 0 (empty buffer reads as zero).
  - rd_pending = 0, occupancy = 0.
- Read accepted at cycle t → memory sampled at edge t+1 → mem_data_i captured at edge t+2 → v_o = 1 in cycle t+2. Read latency is 2.
- Steady state with resp_els_p = 3 and yumi_i held high: one read accepted per cycle, one response per cycle.
- A yumi_i in cycle t frees its credit at edge t+1, so ready rises in cycle t+1 at the earliest.
- Reset asserted mid-operation:
  - The in-flight read is dropped and the buffer is cleared.
  - Memory contents are untouched.
  - Outputs go to their reset values immediately (asynchronous). State is released on the first clk_i edge after deassertion.

## Structure
- Shared package bsg_mem_ctrl_pkg: request struct typedef (w, addr, data, mask), parameterised through macros, for reuse by sibling controllers.
- One sub-module, bsg_mem_1rw_byte_mask_ctrl_rbuf: a resp_els_p-entry register FIFO with wrapping pointers and an occupancy counter. Reset is asynchronous active-low. It exposes its occupancy to the parent for the credit computation.
- The top-level module holds rd_pending, the credit compare and the memory pass-through.

## Test plan
- Reset: hold reset_n_i = 0 → ready_and_o = 1, v_o = 0, mem_v_o = 0. Pull reset low mid-stream with 2 responses buffered → v_o = 0 immediately.
- Write then read: write addr 5, data 0xA1B2C3D4, mask 4'b0101, over prior contents 0xFFFFFFFF. Then read addr 5 → data_o = 0xFFB2FFD4, v_o rising 2 cycles after acceptance.
- Zero mask: write addr 7 with mask 4'b0000 → request accepted, mem_v_o = 0; a later read of addr 7 returns its old value.
- Backpressure: 4 back-to-back reads with yumi_i = 0 → 3 accepted, ready_and_o = 0 from then on. yumi_i for one cycle → ready_and_o = 1 the following cycle; responses arrive in issue order.
- Throughput: 16 consecutive reads with yumi_i = 1 → 16 responses on 16 consecutive cycles, starting 2 cycles after the first accept.
- Simultaneous events: buffer at 2 entries, push and yumi_i in the same cycle → occupancy stays 2, data order preserved.
